i2c_txn_arbiter: RTL and testbench

//  Shares one I2C transaction engine (write-pointer/write-word/read sequencers behind CLOCKMEM tick) among

---
 rtl/i2c_txn_arbiter_if.sv | 33 +++
 rtl/i2c_txn_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// Requester/engine bundle for i2c_txn_arbiter: the arbiter drives the master modport,
// the requesters and the transaction engine sit on the slave modport.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    REQ_RW;
    logic [8*NREQ-1:0]  REQ_SLAVE;
    logic [16*NREQ-1:0] REQ_WDATA;
    logic [NREQ-1:0]    DONE;
    logic               ERR;
    logic [15:0]        RDATA;
    logic [2:0]         GNT_ID;
    logic               BUSY;
    logic               ENG_START;
    logic               ENG_RW;
    logic [7:0]         ENG_SLAVE;
    logic [15:0]        ENG_WDATA;
    logic               ENG_DONE;
    logic               ENG_ACK_OK;
    logic [15:0]        ENG_RDATA;
    logic               ENG_ABORT;

    modport master (
        input  REQ, REQ_RW, REQ_SLAVE, REQ_WDATA, ENG_DONE, ENG_ACK_OK, ENG_RDATA,
        output DONE, ERR, RDATA, GNT_ID, BUSY, ENG_START, ENG_RW, ENG_SLAVE, ENG_WDATA, ENG_ABORT
    );

    modport slave (
        output REQ, REQ_RW, REQ_SLAVE, REQ_WDATA, ENG_DONE, ENG_ACK_OK, ENG_RDATA,
        input  DONE, ERR, RDATA, GNT_ID, BUSY, ENG_START, ENG_RW, ENG_SLAVE, ENG_WDATA, ENG_ABORT
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C transaction engine among NREQ requesters, with bus-free gap
// and timeout watchdog. Define I2C_ARB_PRIO0_EN to give requester 0 fixed priority.
module i2c_txn_arbiter #(
    parameter int NREQ           = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              CLK_50,
    input  logic              RESET,
    input  logic              TICK,
    i2c_txn_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FIN   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [2:0]      GNT_RST      = 3'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0     = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [2:0]      gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;
    logic            eng_start_q, eng_start_d;
    logic            eng_abort_q, eng_abort_d;
    logic            eng_rw_q, eng_rw_d;
    logic [7:0]      eng_slave_q, eng_slave_d;
    logic [15:0]     eng_wdata_q, eng_wdata_d;
    logic [31:0]     cnt_q, cnt_d;

    logic            found_s;
    int              cand_s;
    int              win_s;

    // Winner search: first pending requester after the last grant, wrapping modulo NREQ.
    always_comb begin
        found_s = 1'b0;
        cand_s  = 0;
        win_s   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = int'(gnt_id_q) + k;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && (|(bus.REQ & (ONE_HOT0 << cand_s)))) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
`ifdef I2C_ARB_PRIO0_EN
        // With REQ[0] low the search above already skips requester 0.
        if (bus.REQ[0]) begin
            found_s = 1'b1;
            win_s   = 0;
        end else begin
            win_s = win_s;
        end
`endif
    end

    // Next-state and output logic; everything advances only on TICK, pulses default low.
    always_comb begin
        state_d     = state_q;
        done_d      = {NREQ{1'b0}};
        err_d       = err_q;
        rdata_d     = rdata_q;
        gnt_id_d    = gnt_id_q;
        busy_d      = busy_q;
        eng_start_d = 1'b0;
        eng_abort_d = 1'b0;
        eng_rw_d    = eng_rw_q;
        eng_slave_d = eng_slave_q;
        eng_wdata_d = eng_wdata_q;
        cnt_d       = cnt_q;
        if (TICK) begin
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt_id_d    = 3'(win_s);
                        eng_rw_d    = 1'(bus.REQ_RW >> win_s);
                        eng_slave_d = 8'(bus.REQ_SLAVE >> (8 * win_s));
                        eng_wdata_d = 16'(bus.REQ_WDATA >> (16 * win_s));
                        busy_d      = 1'b1;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    eng_start_d = 1'b1;
                    cnt_d       = 32'd0;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the final watchdog tick takes precedence over the abort.
                    if (bus.ENG_DONE) begin
                        err_d = ~bus.ENG_ACK_OK;
                        if (eng_rw_q) begin
                            rdata_d = bus.ENG_RDATA;
                        end else begin
                            rdata_d = rdata_q;
                        end
                        state_d = ST_FIN;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        eng_abort_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = ST_FIN;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_FIN: begin
                    done_d = ONE_HOT0 << gnt_id_q;
                    cnt_d  = 32'd0;
                    if (GAP_CYCLES == 0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            done_q      <= {NREQ{1'b0}};
            err_q       <= 1'b0;
            rdata_q     <= 16'h0000;
            gnt_id_q    <= GNT_RST;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            eng_rw_q    <= 1'b0;
            eng_slave_q <= 8'h00;
            eng_wdata_q <= 16'h0000;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            gnt_id_q    <= gnt_id_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
            eng_rw_q    <= eng_rw_d;
            eng_slave_q <= eng_slave_d;
            eng_wdata_q <= eng_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.RDATA     = rdata_q;
    assign bus.GNT_ID    = gnt_id_q;
    assign bus.BUSY      = busy_q;
    assign bus.ENG_START = eng_start_q;
    assign bus.ENG_ABORT = eng_abort_q;
    assign bus.ENG_RW    = eng_rw_q;
    assign bus.ENG_SLAVE = eng_slave_q;
    assign bus.ENG_WDATA = eng_wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter (NREQ=4, GAP=16, TIMEOUT=50); TICK strobes every other clock.
module tb_i2c_txn_arbiter;

    logic clk = 1'b0;
    logic RESET;
    logic TICK;

    int n_tests = 0;
    int n_fail = 0;
    int pulse_leak = 0;
    logic       s_start;
    logic       s_abort;
    logic [3:0] s_done;

    i2c_txn_arbiter_if #(.NREQ(4)) bus ();

    i2c_txn_arbiter #(.NREQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(50)) dut (
        .CLK_50 (clk),
        .RESET  (RESET),
        .TICK   (TICK),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // One tick: a TICK cycle (pulses sampled after it) then a quiet cycle where pulses must be low.
    task automatic tick_step();
        TICK = 1'b1;
        @(posedge clk); #1;
        TICK = 1'b0;
        bus.ENG_DONE = 1'b0;
        s_start = bus.ENG_START;
        s_abort = bus.ENG_ABORT;
        s_done  = bus.DONE;
        @(posedge clk); #1;
        if (bus.ENG_START !== 1'b0 || bus.ENG_ABORT !== 1'b0 || bus.DONE !== 4'b0000) pulse_leak++;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick_step();
            if (s_start === 1'b1) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wait_start: ENG_START not seen within 64 ticks"); end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick_step();
            if (s_done !== 4'b0000) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wait_done: DONE not seen within 8 ticks"); end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick_step();
            if (bus.BUSY === 1'b0) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wait_idle: BUSY still high after 64 ticks"); end
    endtask

    task automatic test_reset();
        RESET = 1'b1; tick_step(); tick_step(); RESET = 1'b0;
        n_tests++;
        if ({bus.DONE, bus.ERR, bus.BUSY, bus.ENG_START, bus.ENG_ABORT, bus.ENG_RW} !== 9'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000000",
                {bus.DONE, bus.ERR, bus.BUSY, bus.ENG_START, bus.ENG_ABORT, bus.ENG_RW});
        end
        n_tests++;
        if (bus.GNT_ID !== 3'd3) begin n_fail++; $display("FAIL reset_gnt: got %0d expected 3", bus.GNT_ID); end
        n_tests++;
        if ({bus.RDATA, bus.ENG_SLAVE, bus.ENG_WDATA} !== 40'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.RDATA, bus.ENG_SLAVE, bus.ENG_WDATA});
        end
    endtask

    task automatic test_single_write();
        int n;
        int starts;
        bit ok;
        bus.REQ_RW    = 4'b0000;
        bus.REQ_SLAVE = {8'h33, 8'h22, 8'h18, 8'h11};
        bus.REQ_WDATA = {16'h4444, 16'h3333, 16'h3F20, 16'h1111};
        bus.REQ       = 4'b0010;
        tick_step();
        n_tests++;
        if (bus.GNT_ID !== 3'd1 || bus.BUSY !== 1'b1 || s_start !== 1'b0) begin
            n_fail++; $display("FAIL wr_grant: got gnt=%0d busy=%b start=%b expected 1 1 0", bus.GNT_ID, bus.BUSY, s_start);
        end
        tick_step();
        n_tests++;
        if (s_start !== 1'b1) begin n_fail++; $display("FAIL wr_start: got %b expected 1", s_start); end
        bus.REQ_SLAVE = {8'h33, 8'h22, 8'h7E, 8'h11};
        bus.REQ_WDATA = {16'h4444, 16'h3333, 16'hDEAD, 16'h1111};
        starts = 0;
        for (int i = 0; i < 39; i++) begin
            tick_step();
            if (s_start === 1'b1) starts++;
        end
        bus.ENG_ACK_OK = 1'b1; bus.ENG_DONE = 1'b1; tick_step();
        n_tests++;
        if (s_done !== 4'b0000 || starts != 0) begin
            n_fail++; $display("FAIL wr_early: got done=%b starts=%0d expected 0000 0", s_done, starts);
        end
        tick_step();
        n_tests++;
        if (s_done !== 4'b0010 || bus.ERR !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got done=%b err=%b expected 0010 0", s_done, bus.ERR);
        end
        n_tests++;
        if (bus.ENG_SLAVE !== 8'h18 || bus.ENG_WDATA !== 16'h3F20 || bus.ENG_RW !== 1'b0) begin
            n_fail++; $display("FAIL wr_latch: got %h %h %b expected 18 3f20 0", bus.ENG_SLAVE, bus.ENG_WDATA, bus.ENG_RW);
        end
        bus.REQ = 4'b0000;
        n = 0; ok = 1'b0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            tick_step();
            if (bus.BUSY === 1'b0) begin ok = 1'b1; n = i; end
        end
        n_tests++;
        if (n != 16) begin n_fail++; $display("FAIL wr_gap: got busy low after %0d ticks expected 16", n); end
    endtask

    task automatic test_fairness();
        int exp_order[5];
        logic [3:0] exp_v;
        bit ok;
        exp_order = '{0, 1, 2, 3, 0};
        RESET = 1'b1; tick_step(); RESET = 1'b0;
        bus.REQ_RW = 4'b0000; bus.ENG_ACK_OK = 1'b1; bus.REQ = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_start(ok);
            n_tests++;
            if (bus.GNT_ID !== 3'(exp_order[t])) begin
                n_fail++; $display("FAIL fair_gnt[%0d]: got %0d expected %0d", t, bus.GNT_ID, exp_order[t]);
            end
            for (int i = 0; i < 4; i++) tick_step();
            bus.ENG_DONE = 1'b1; tick_step();
            wait_done(ok);
            exp_v = 4'b0001 << exp_order[t];
            n_tests++;
            if (s_done !== exp_v) begin n_fail++; $display("FAIL fair_done[%0d]: got %b expected %b", t, s_done, exp_v); end
        end
        bus.REQ = 4'b0000;
        wait_idle();
    endtask

    task automatic test_read();
        bit ok;
        bus.REQ_RW    = 4'b0100;
        bus.REQ_SLAVE = {8'h33, 8'h48, 8'h18, 8'h11};
        bus.REQ       = 4'b0100;
        wait_start(ok);
        n_tests++;
        if (bus.GNT_ID !== 3'd2 || bus.ENG_RW !== 1'b1 || bus.ENG_SLAVE !== 8'h48) begin
            n_fail++; $display("FAIL rd_grant: got %0d %b %h expected 2 1 48", bus.GNT_ID, bus.ENG_RW, bus.ENG_SLAVE);
        end
        for (int i = 0; i < 3; i++) tick_step();
        bus.ENG_RDATA = 16'hA55A; bus.ENG_ACK_OK = 1'b1; bus.ENG_DONE = 1'b1; tick_step();
        bus.ENG_RDATA = 16'h0000;
        wait_done(ok);
        n_tests++;
        if (s_done !== 4'b0100 || bus.RDATA !== 16'hA55A || bus.ERR !== 1'b0) begin
            n_fail++; $display("FAIL rd_done: got %b %h %b expected 0100 a55a 0", s_done, bus.RDATA, bus.ERR);
        end
        bus.REQ = 4'b0000;
        bus.ENG_RDATA = 16'h0BAD; bus.ENG_DONE = 1'b1; tick_step();
        n_tests++;
        if (s_done !== 4'b0000 || bus.RDATA !== 16'hA55A) begin
            n_fail++; $display("FAIL rd_stray: got %b %h expected 0000 a55a", s_done, bus.RDATA);
        end
        wait_idle();
        bus.REQ_RW = 4'b0000; bus.REQ = 4'b1000;
        wait_start(ok);
        bus.ENG_RDATA = 16'h1234; bus.ENG_DONE = 1'b1; tick_step();
        wait_done(ok);
        n_tests++;
        if (s_done !== 4'b1000 || bus.RDATA !== 16'hA55A) begin
            n_fail++; $display("FAIL rd_hold: got %b %h expected 1000 a55a", s_done, bus.RDATA);
        end
        bus.REQ = 4'b0000;
        wait_idle();
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        bus.REQ = 4'b0001;
        wait_start(ok);
        n = 0;
        for (int i = 1; i <= 80 && n == 0; i++) begin
            tick_step();
            if (s_abort === 1'b1) n = i;
        end
        n_tests++;
        if (n != 50 || s_done !== 4'b0000) begin
            n_fail++; $display("FAIL to_abort: got abort at tick %0d done=%b expected 50 0000", n, s_done);
        end
        tick_step();
        n_tests++;
        if (s_done !== 4'b0001 || bus.ERR !== 1'b1 || bus.BUSY !== 1'b1) begin
            n_fail++; $display("FAIL to_done: got %b err=%b busy=%b expected 0001 1 1", s_done, bus.ERR, bus.BUSY);
        end
        bus.REQ = 4'b0000;
        wait_idle();
        bus.REQ = 4'b0001;
        wait_start(ok);
        for (int i = 0; i < 49; i++) tick_step();
        bus.ENG_ACK_OK = 1'b1; bus.ENG_DONE = 1'b1; tick_step();
        n_tests++;
        if (s_abort !== 1'b0) begin n_fail++; $display("FAIL to_race_abort: got %b expected 0", s_abort); end
        tick_step();
        n_tests++;
        if (s_done !== 4'b0001 || bus.ERR !== 1'b0) begin
            n_fail++; $display("FAIL to_race_done: got %b err=%b expected 0001 0", s_done, bus.ERR);
        end
        bus.REQ = 4'b0000;
        wait_idle();
    endtask

    task automatic test_nack_reset();
        int dones;
        bit ok;
        bus.REQ = 4'b0010;
        wait_start(ok);
        tick_step(); tick_step();
        bus.ENG_ACK_OK = 1'b0; bus.ENG_DONE = 1'b1; tick_step();
        bus.ENG_ACK_OK = 1'b1;
        wait_done(ok);
        n_tests++;
        if (s_done !== 4'b0010 || bus.ERR !== 1'b1) begin
            n_fail++; $display("FAIL nack: got %b err=%b expected 0010 1", s_done, bus.ERR);
        end
        bus.REQ = 4'b0000;
        wait_idle();
        bus.REQ = 4'b0100;
        wait_start(ok);
        for (int i = 0; i < 3; i++) tick_step();
        RESET = 1'b1; tick_step(); RESET = 1'b0;
        bus.REQ = 4'b0000;
        n_tests++;
        if ({bus.DONE, bus.ERR, bus.BUSY, bus.ENG_START, bus.ENG_ABORT, bus.ENG_RW, bus.GNT_ID} !== {9'd0, 3'd3}) begin
            n_fail++; $display("FAIL mid_reset_ctl: got %b expected 000000000011",
                {bus.DONE, bus.ERR, bus.BUSY, bus.ENG_START, bus.ENG_ABORT, bus.ENG_RW, bus.GNT_ID});
        end
        n_tests++;
        if ({bus.RDATA, bus.ENG_SLAVE, bus.ENG_WDATA} !== 40'd0) begin
            n_fail++; $display("FAIL mid_reset_data: got %h expected 0", {bus.RDATA, bus.ENG_SLAVE, bus.ENG_WDATA});
        end
        dones = 0;
        bus.ENG_DONE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_step();
            if (s_done !== 4'b0000) dones++;
        end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("FAIL mid_reset_nodone: got %0d DONE pulses expected 0", dones); end
    endtask

    task automatic test_sole_regrant();
        int n;
        bit ok;
        RESET = 1'b1; tick_step(); RESET = 1'b0;
        bus.REQ_RW = 4'b0000; bus.REQ = 4'b0010;
        wait_start(ok);
        bus.ENG_DONE = 1'b1; tick_step();
        wait_done(ok);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick_step();
            if (s_start === 1'b1) n = i;
        end
        n_tests++;
        if (n != 18 || bus.GNT_ID !== 3'd1) begin
            n_fail++; $display("FAIL sole_regrant: got start after %0d ticks gnt=%0d expected 18 1", n, bus.GNT_ID);
        end
        bus.ENG_DONE = 1'b1; tick_step();
        wait_done(ok);
        bus.REQ = 4'b0000;
        wait_idle();
    endtask

    task automatic test_prio0();
        logic [2:0] exp_gnt;
        bit ok;
`ifdef I2C_ARB_PRIO0_EN
        exp_gnt = 3'd0;
`else
        exp_gnt = 3'd3;
`endif
        RESET = 1'b1; tick_step(); RESET = 1'b0;
        bus.REQ = 4'b1100;
        wait_start(ok);
        n_tests++;
        if (bus.GNT_ID !== 3'd2) begin n_fail++; $display("FAIL prio_first: got %0d expected 2", bus.GNT_ID); end
        tick_step();
        bus.REQ = 4'b1101;
        tick_step();
        bus.ENG_DONE = 1'b1; tick_step();
        wait_done(ok);
        bus.REQ = 4'b1001;
        wait_start(ok);
        n_tests++;
        if (bus.GNT_ID !== exp_gnt) begin n_fail++; $display("FAIL prio_next: got %0d expected %0d", bus.GNT_ID, exp_gnt); end
        bus.ENG_DONE = 1'b1; tick_step();
        wait_done(ok);
        bus.REQ = 4'b0000;
        wait_idle();
    endtask

    task automatic test_pulse_width();
        n_tests++;
        if (pulse_leak != 0) begin
            n_fail++; $display("FAIL pulse_width: got %0d pulses in non-TICK cycles expected 0", pulse_leak);
        end
    endtask

    initial begin
        RESET = 1'b1; TICK = 1'b0;
        bus.REQ = 4'b0000; bus.REQ_RW = 4'b0000; bus.REQ_SLAVE = 32'h0; bus.REQ_WDATA = 64'h0;
        bus.ENG_DONE = 1'b0; bus.ENG_ACK_OK = 1'b1; bus.ENG_RDATA = 16'h0000;
        test_reset();
        test_single_write();
        test_fairness();
        test_read();
        test_timeout();
        test_nack_reset();
        test_sole_regrant();
        test_prio0();
        test_pulse_width();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
